// File: rtl/rf_wr_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_wr_arb_pkg;

    localparam logic [4:0] RF_ZERO    = 5'd0;
    localparam int         ARB_P0     = 0;
    localparam int         ARB_P1     = 1;
    localparam int         STARVE_W   = 4;
    localparam int         FIFO_DEPTH = 2;

    localparam logic RR_P0 = 1'(ARB_P0);
    localparam logic RR_P1 = 1'(ARB_P1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_P0,
        GNT_P1
    } grant_e;

    function automatic grant_e rrGrant(input logic rr);
        return (rr == RR_P1) ? GNT_P1 : GNT_P0;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Two-entry FIFO holding pending peripheral register writes; the head entry
// is visible combinationally so it can be written in the cycle it is granted.
module rf_wr_fifo
    import rf_wr_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    input  logic          i_pop,
    output logic [1:0]    o_count,
    output logic [AW-1:0] o_headWa,
    output logic [DW-1:0] o_headWd
);

    logic [AW-1:0] r_memWa [2];
    logic [DW-1:0] r_memWd [2];
    logic          r_wrPtr;
    logic          r_rdPtr;
    logic [1:0]    r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPush = i_push && (r_count != 2'(FIFO_DEPTH));
    assign w_doPop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) r_wrPtr <= ~r_wrPtr;
            if (w_doPop)  r_rdPtr <= ~r_rdPtr;
            if (w_doPush && !w_doPop)      r_count <= r_count + 2'd1;
            else if (w_doPop && !w_doPush) r_count <= r_count - 2'd1;
        end
    end

    // Storage needs no reset: a zero count already marks every entry dead.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_memWa[r_wrPtr] <= i_wa;
            r_memWd[r_wrPtr] <= i_wd;
        end
    end

    assign o_count  = r_count;
    assign o_headWa = r_memWa[r_rdPtr];
    assign o_headWd = r_memWd[r_rdPtr];

endmodule

// File: rtl/rf_wr_arb.sv
// Shares the register file's single write port between core writeback and two
// buffered peripheral writers, draining them round-robin with a starvation stall.
module rf_wr_arb
    import rf_wr_arb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_wa,
    input  logic [DW-1:0] i_cpu_wd,
    input  logic          i_p0_valid,
    output logic          o_p0_ready,
    input  logic [AW-1:0] i_p0_wa,
    input  logic [DW-1:0] i_p0_wd,
    input  logic          i_p1_valid,
    output logic          o_p1_ready,
    input  logic [AW-1:0] i_p1_wa,
    input  logic [DW-1:0] i_p1_wd,
    output logic          o_stall,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_wa,
    output logic [DW-1:0] o_rf_wd
);

    localparam logic [STARVE_W-1:0] WAIT_LIMIT = STARVE_W'(STARVE_MAX);
    localparam logic [AW-1:0]       ZERO_WA    = AW'(RF_ZERO);

    logic                w_push     [2];
    logic                w_pop      [2];
    logic                w_nonEmpty [2];
    logic                w_starve   [2];
    logic [1:0]          w_count    [2];
    logic [AW-1:0]       w_headWa   [2];
    logic [DW-1:0]       w_headWd   [2];
    logic [STARVE_W-1:0] r_wait     [2];
    logic                r_rr;
    logic                w_portSel;
    grant_e              w_grant;

    assign o_p0_ready     = (w_count[ARB_P0] != 2'(FIFO_DEPTH)) && !i_rst;
    assign o_p1_ready     = (w_count[ARB_P1] != 2'(FIFO_DEPTH)) && !i_rst;
    assign w_push[ARB_P0] = i_p0_valid && o_p0_ready;
    assign w_push[ARB_P1] = i_p1_valid && o_p1_ready;
    assign w_pop[ARB_P0]  = (w_grant == GNT_P0);
    assign w_pop[ARB_P1]  = (w_grant == GNT_P1);

    rf_wr_fifo #(.DW(DW), .AW(AW)) u_fifo0 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_push[ARB_P0]),
        .i_wa     (i_p0_wa),
        .i_wd     (i_p0_wd),
        .i_pop    (w_pop[ARB_P0]),
        .o_count  (w_count[ARB_P0]),
        .o_headWa (w_headWa[ARB_P0]),
        .o_headWd (w_headWd[ARB_P0])
    );

    rf_wr_fifo #(.DW(DW), .AW(AW)) u_fifo1 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_push[ARB_P1]),
        .i_wa     (i_p1_wa),
        .i_wd     (i_p1_wd),
        .i_pop    (w_pop[ARB_P1]),
        .o_count  (w_count[ARB_P1]),
        .o_headWa (w_headWa[ARB_P1]),
        .o_headWd (w_headWd[ARB_P1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_port
        assign w_nonEmpty[g] = (w_count[g] != 2'd0);
        assign w_starve[g]   = w_nonEmpty[g] && (r_wait[g] == WAIT_LIMIT);
    end

    assign o_stall = (w_starve[ARB_P0] || w_starve[ARB_P1]) && !i_rst;

    // A starved head outranks the core; otherwise the core always wins.
    always_comb begin
        w_grant = GNT_NONE;
        if (i_rst)
            w_grant = GNT_NONE;
        else if (w_starve[ARB_P0] && w_starve[ARB_P1])
            w_grant = rrGrant(r_rr);
        else if (w_starve[ARB_P0])
            w_grant = GNT_P0;
        else if (w_starve[ARB_P1])
            w_grant = GNT_P1;
        else if (i_cpu_we && (i_cpu_wa != ZERO_WA))
            w_grant = GNT_CPU;
        else if (w_nonEmpty[ARB_P0] && ((r_rr == RR_P0) || !w_nonEmpty[ARB_P1]))
            w_grant = GNT_P0;
        else if (w_nonEmpty[ARB_P1])
            w_grant = GNT_P1;
    end

    assign w_portSel = (w_grant == GNT_P1);

    // A granted peripheral head aimed at $zero is consumed without a write.
    always_comb begin
        o_rf_we = 1'b0;
        o_rf_wa = '0;
        o_rf_wd = '0;
        case (w_grant)
            GNT_CPU: begin
                o_rf_we = 1'b1;
                o_rf_wa = i_cpu_wa;
                o_rf_wd = i_cpu_wd;
            end
            GNT_P0, GNT_P1: begin
                if (w_headWa[w_portSel] != ZERO_WA) begin
                    o_rf_we = 1'b1;
                    o_rf_wa = w_headWa[w_portSel];
                    o_rf_wd = w_headWd[w_portSel];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr <= RR_P0;
            for (int p = 0; p < 2; p++) r_wait[p] <= '0;
        end else begin
            if (w_pop[ARB_P0])      r_rr <= RR_P1;
            else if (w_pop[ARB_P1]) r_rr <= RR_P0;
            for (int p = 0; p < 2; p++) begin
                if (!w_nonEmpty[p] || w_pop[p])
                    r_wait[p] <= '0;
                else if (r_wait[p] != WAIT_LIMIT)
                    r_wait[p] <= r_wait[p] + STARVE_W'(1);
            end
        end
    end

endmodule

// File: doc/rf_wr_arb.md
Name: rf_wr_arb

Overview:
Write-port arbiter for the 32x32 register file. The single-cycle core and two peripheral writers share the file's one write port. Peripheral writers are UART RX (port 0) and timer event (port 1).
- The core's writeback always passes straight through in the same cycle, except on a starvation stall.
- Peripheral writes are buffered in 2-entry FIFOs and drained round-robin in cycles the core leaves free.
- Sits between core writeback/peripherals and reg_file's we/wa/wd inputs.

Parameters:
DW, 32, data width
AW, 5, register address width
STARVE_MAX, 4, cycles a peripheral FIFO head may wait before a core stall is forced (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_we  in  1  core writeback enable
cpu_wa  in  AW  core writeback address
cpu_wd  in  DW  core writeback data
p0_valid  in  1  UART RX write request
p0_ready  out  1  port 0 FIFO can accept
p0_wa  in  AW  port 0 address
p0_wd  in  DW  port 0 data
p1_valid  in  1  timer write request
p1_ready  out  1  port 1 FIFO can accept
p1_wa  in  AW  port 1 address
p1_wd  in  DW  port 1 data
stall  out  1  core must hold PC; its writeback is ignored this cycle
rf_we  out  1  to reg_file we
rf_wa  out  AW  to reg_file wa
rf_wd  out  DW  to reg_file wd

Behaviour:
Reset:
- rst high clears both FIFOs (count=0, entries discarded even mid-drain), both wait counters, and rr=0.
- Outputs while rst high: rf_we=0, stall=0, p0_ready=p1_ready=0.
- Release to ready=1 on the first cycle after deassertion.

Peripheral FIFOs:
- Push on the posedge where pN_valid && pN_ready.
- pN_ready = (countN<2) && !rst, derived from registered count only; no valid->ready combinational path.
- Push and pop in the same cycle leave the count unchanged.
- Minimum accept-to-rf_we latency is 1 cycle.

Grant selection (combinational, priority order):
1. stall: some head has waitN==STARVE_MAX. Grant that port; if both qualify, grant port rr.
2. cpu_we && cpu_wa!=0: grant the core; rf_w* = cpu_w*.
3. Any FIFO non-empty: grant port rr if non-empty, else the other port.
4. Otherwise rf_we=0; rf_wa/rf_wd are don't-care and driven 0.

Effects of a grant:
- A peripheral grant pops that FIFO head; rr flips to the other port on that posedge.
- A peripheral head with wa==0 is popped with rf_we=0, so register $zero is never written. This still counts as a grant.
- A core write to wa==0 gives rf_we=0 and does not block peripherals.
- During stall, cpu_we is ignored; the core re-presents the same writeback next cycle.

Wait counters:
- waitN increments each cycle FIFO N is non-empty and not granted.
- Clears on grant of N, or when FIFO N is empty.
- Saturates at STARVE_MAX.
- stall is a registered-counter decode, high for exactly one cycle per starvation event.

Other rules:
- Only one write reaches rf per cycle; no data is merged.
- Per-port order is FIFO-preserving.

Decomposition:
- Shared include (alongside the register address defines): `RF_ZERO (5'd0), `ARB_P0 / `ARB_P1 port indices, STARVE counter width (4).
- One sub-module, rf_wr_fifo: 2-entry FIFO with push/pop, count, head data/address, async reset. Instantiated twice.
- Grant logic, rr and wait counters live in rf_wr_arb.

Test Plan:
- Reset mid-drain: p0 holds 2 entries, rst pulses high for 1 cycle -> rf_we=0 during rst, p0_ready=1 next cycle, the entries are never written.
- Idle core: p0 pushes (wa=5, wd=0xA5) at cycle 0, cpu_we=0 -> rf_we=1, wa=5, wd=0xA5 at cycle 1; p0_ready stays 1.
- Round-robin: both ports push one entry in the same cycle, rr=0 -> p0 written cycle 1, p1 cycle 2, rr back to 0.
- Starvation: cpu_we=1 (wa=3) every cycle, p1 pushes (wa=7, wd=0x1234) at cycle 0, STARVE_MAX=4 -> stall=1 and rf write wa=7 at cycle 5; core write resumes at cycle 6.
- Zero address: p0 pushes wa=0, then wa=9 -> no rf_we for wa=0, wa=9 written one cycle later. cpu_we=1, cpu_wa=0 while p1 is non-empty -> p1 granted.
- Backpressure: p0_valid held high with 3 distinct writes while the core writes every cycle -> p0_ready=0 after 2 accepts; writes land in order 1, 2, 3 with no loss or duplication.
